// File: rtl/seven_segment_mux_driver.sv
// Binary-to-decimal multiplexed seven-segment driver: sequential double-dabble
// conversion feeding a registered digit scan with optional leading-zero blanking.
module seven_segment_mux_driver #(
   parameter int WIDTH       = 8,
   parameter int DIGITS      = 3,
   parameter int REFRESH_DIV = 1000,
   parameter int ACTIVE_LOW  = 0,
   parameter int BLANK_LZ    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [WIDTH-1:0]  num,
   output logic              busy,
   output logic              overflow,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] an
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic POL = (ACTIVE_LOW != 0);

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

   localparam logic [63:0] LIMIT = pow10(DIGITS);

   function automatic logic [6:0] enc(input logic [3:0] d);
      case (d)
         4'd0:    enc = 7'h3F;
         4'd1:    enc = 7'h06;
         4'd2:    enc = 7'h5B;
         4'd3:    enc = 7'h4F;
         4'd4:    enc = 7'h66;
         4'd5:    enc = 7'h6D;
         4'd6:    enc = 7'h7D;
         4'd7:    enc = 7'h07;
         4'd8:    enc = 7'h7F;
         4'd9:    enc = 7'h6F;
         default: enc = 7'h00;
      endcase
   endfunction

   typedef enum logic {IDLE, CONV} state_t;

   state_t              state_q, state_d;
   logic                accept, commit, last;
   logic [CW-1:0]       cnt_q;
   logic [WIDTH-1:0]    sr_q, sr_nx;
   logic [4*DIGITS-1:0] bcd_q, bcd_adj, bcd_nx;
   logic                ovf_pend_q, ovf_q;
   logic [4*DIGITS-1:0] disp_q;

   assign last     = (state_q == CONV) && (cnt_q == CW'(WIDTH - 1));
   assign busy     = (state_q == CONV);
   assign overflow = ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      commit  = 1'b0;
      case (state_q)
         IDLE: if (load) begin
            accept  = 1'b1;
            state_d = CONV;
         end
         CONV: if (last) begin
            commit  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // One double-dabble step: correct nibbles >= 5, then shift the whole {bcd,sr} left.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      {bcd_nx, sr_nx} = {bcd_adj, sr_q} << 1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         sr_q       <= '0;
         bcd_q      <= '0;
         ovf_pend_q <= 1'b0;
         disp_q     <= '0;
         ovf_q      <= 1'b0;
      end else begin
         if (accept) begin
            sr_q       <= num;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= ({{(64-WIDTH){1'b0}}, num} >= LIMIT);
         end else if (state_q == CONV) begin
            sr_q  <= sr_nx;
            bcd_q <= bcd_nx;
            cnt_q <= cnt_q + 1'b1;
         end
         if (commit) begin
            disp_q <= bcd_nx;
            ovf_q  <= ovf_pend_q;
         end
      end
   end

   logic [RW-1:0]     rcnt_q;
   logic [IW-1:0]     idx_q, idx_nx;
   logic              rwrap;
   logic [DIGITS-1:0] blank;
   logic              zero_above, blk;
   logic [3:0]        digit;
   logic [6:0]        pat;

   assign rwrap  = (rcnt_q == RW'(REFRESH_DIV - 1));
   assign idx_nx = !rwrap ? idx_q : (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

   // The output register is loaded from the next index so an/seg move with the counter wrap.
   always_comb begin
      zero_above = 1'b1;
      blank      = '0;
      digit      = 4'd0;
      blk        = 1'b0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_above = zero_above && (disp_q[4*k +: 4] == 4'd0);
         blank[k]   = (BLANK_LZ != 0) && (k != 0) && zero_above;
      end
      for (int k = 0; k < DIGITS; k++) begin
         if (IW'(k) == idx_nx) begin
            digit = disp_q[4*k +: 4];
            blk   = blank[k];
         end
      end
      if (ovf_q)    pat = 7'h40;
      else if (blk) pat = 7'h00;
      else          pat = enc(digit);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcnt_q <= '0;
         idx_q  <= '0;
         seg    <= {7{POL}} ^ 7'h3F;
         an     <= {DIGITS{POL}} ^ DIGITS'(1);
      end else begin
         rcnt_q <= rwrap ? '0 : rcnt_q + 1'b1;
         idx_q  <= idx_nx;
         seg    <= {7{POL}} ^ pat;
         an     <= {DIGITS{POL}} ^ (DIGITS'(1) << idx_nx);
      end
   end

endmodule

// File: doc/seven_segment_mux_driver.md
# seven_segment_mux_driver

Parametrised multi-digit seven-segment display driver that converts an unsigned binary value to decimal and time-multiplexes it across a common-segment, per-digit-enable display. It is the successor to the single-pattern seven-segment LED driver and supports configurable input width, digit count, refresh rate, output polarity and leading-zero blanking. It sits between core logic that produces a binary result and the board's segment/digit-enable pins.

## Interface
- WIDTH, 8: bit width of `num`; range 1..32.
- DIGITS, 3: number of displayed decimal digits; range 1..8.
- REFRESH_DIV, 1000: clock cycles each digit stays enabled; must be at least 1.
- ACTIVE_LOW, 0: when 1, `seg` and `an` are inverted at the output register.
- BLANK_LZ, 1: when 1, leading zeros are blanked. Digit 0 is never blanked.

- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- load  in  1  single-cycle request to capture `num`.
- num  in  WIDTH  unsigned value to display.
- busy  out  1  conversion in progress; `load` is ignored while high.
- overflow  out  1  the last accepted value is at least 10^DIGITS.
- seg  out  7  segment pattern {g,f,e,d,c,b,a}; active-high when ACTIVE_LOW=0.
- an  out  DIGITS  one-hot digit enable; `an[0]` is the ones digit.

## Operation
- **State machine:** IDLE -> CONV -> IDLE.
  - IDLE with `load`=1: capture `num` into the shift register. Clear the BCD accumulator. Compute the overflow compare (`num` >= 10^DIGITS, a constant fixed at elaboration). Go to CONV.
  - CONV: one iteration of sequential double-dabble per cycle (add 3 to any nibble >= 5, then shift left by one), for exactly WIDTH cycles.
  - Last CONV cycle: commit the BCD digits and the overflow flag to the display registers in the same edge, then go to IDLE.
- **Display registers** are updated only at commit. The scan continues from the old content during conversion, so the display never shows a partial result.
- **Overflow:** when committed overflow=1, every digit shows a dash (g only, 7'b1000000) and blanking is not applied. When overflow=0, each digit shows its BCD nibble.
- **Segment encoding**, 0..9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex, active-high). A blanked digit is 7'b0000000.
- **Blanking** (BLANK_LZ=1): digit k>0 is blanked when it and all higher digits are zero.
- **Scan:**
  - The refresh counter counts 0..REFRESH_DIV-1.
  - When it wraps, the digit index advances, wrapping from DIGITS-1 to 0.
  - `an` is one-hot at the index; `seg` holds the pattern for that index.
  - Both are registered and change on the same edge.
- **Polarity:** ACTIVE_LOW inverts only the final `seg` and `an` registers.
- **Load while busy** is dropped and has no side effects.

## Timing
- **Reset values:** busy=0, overflow=0, display value 0, digit index 0, refresh counter 0, state IDLE.
  - `an` reset value is 1 on bit 0, 0 elsewhere.
  - `seg` reset value is 7'h3F.
  - Both are inverted if ACTIVE_LOW=1.
- **Accept:** `load` sampled high in IDLE raises `busy` on the next edge.
- **Busy duration:** `busy` stays high for exactly WIDTH cycles.
- **Commit:** occurs on the edge where `busy` falls. `overflow` updates on that same edge.
- **Display latency:** `seg`/`an` reflect the new value starting with the first output register update after commit, i.e. 1 cycle after `busy` falls for the enabled digit.
- **Back-to-back loads:** a `load` in the cycle `busy` falls is accepted, giving a throughput of one value per WIDTH+1 cycles.
- **Digit dwell:** each digit is enabled for exactly REFRESH_DIV cycles. A full frame is DIGITS*REFRESH_DIV cycles. The scan is independent of `load`.
- **Reset mid-conversion:** the conversion is abandoned and all registers return to reset values immediately (asynchronous). No partial commit occurs.

## Test plan
- **Reset:** assert rst_n=0, release. Expect `an`=001, `seg`=7'h3F, busy=0, overflow=0, and digits 1 and 2 blanked (7'h00) when scanned.
- **Conversion** (WIDTH=8, DIGITS=3, REFRESH_DIV=4): pulse `load` with `num`=123. Expect `busy` high for 8 cycles. After commit, the scan shows 4F on `an`=001, 5B on 010, 06 on 100, each for 4 cycles.
- **Blanking:** `num`=7 with BLANK_LZ=1 gives 07 / 00 / 00. Repeat with BLANK_LZ=0: expect 07 / 3F / 3F.
- **Overflow** (DIGITS=2): `num`=255 gives overflow=1 and both digits 7'h40. A following `num`=99 clears overflow and shows 6F / 6F.
- **Load while busy:** load 42, then load 99 two cycles later. Expect 42 displayed and only one busy pulse. A `load` on the busy-fall cycle is accepted.
- **Mid-conversion reset and polarity:** assert rst_n during CONV and expect reset values with no commit. With ACTIVE_LOW=1 after reset, expect `an`=110 and `seg`=7'h40.
